// File: rtl/sdram_bridge_pkg.sv
// rtl/sdram_bridge_pkg.sv - shared types and constants for the 32-to-16 bit SDRAM word bridge
package sdram_bridge_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    RD_WAIT,
    DONE
  } bridge_state_t;

endpackage

// File: rtl/sdram_word_bridge.sv
// rtl/sdram_word_bridge.sv - splits 32-bit client word requests into pairs of 16-bit Avalon-MM transfers
module sdram_word_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic              avm_clk,
  input  logic              avm_rst_n,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic              sdram_read,
  input  logic              sdram_write,
  input  logic [31:0]       sdram_writedata,
  output logic [31:0]       sdram_readdata,
  output logic              sdram_finished,
  output logic [ADDR_W:0]   sdr_address,
  output logic              sdr_read,
  output logic              sdr_write,
  output logic [15:0]       sdr_writedata,
  input  logic [15:0]       sdr_readdata,
  input  logic              sdr_readdatavalid,
  input  logic              sdr_waitrequest
);

  bridge_state_t     state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] data_q, data_n;
  logic [1:0]        cnt_q, cnt_n;
  logic [HALF_W-1:0] lo_q, lo_n, hi_q, hi_n;
  logic              in_read;
  logic              beat;
  logic              half_sel;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    lo_n    = lo_q;
    hi_n    = hi_q;

    // Beats are only meaningful while a read is in flight; the count saturates at two.
    in_read = (state == RD_LO) || (state == RD_HI) || (state == RD_WAIT);
    beat    = sdr_readdatavalid && in_read && (cnt_q != 2'd2);
    if (beat) begin
      if (cnt_q == 2'd0) begin
        lo_n = sdr_readdata;
      end else begin
        hi_n = sdr_readdata;
      end
      cnt_n = cnt_q + 2'd1;
    end

    case (state)
      IDLE: begin
        if (sdram_write) begin
          addr_n  = sdram_addr;
          data_n  = sdram_writedata;
          state_n = WR_LO;
        end else if (sdram_read) begin
          addr_n  = sdram_addr;
          cnt_n   = 2'd0;
          state_n = RD_LO;
        end
      end
      WR_LO:   if (!sdr_waitrequest) state_n = WR_HI;
      WR_HI:   if (!sdr_waitrequest) state_n = DONE;
      RD_LO:   if (!sdr_waitrequest) state_n = RD_HI;
      RD_HI:   if (!sdr_waitrequest) state_n = RD_WAIT;
      RD_WAIT: if (cnt_n == 2'd2) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    half_sel = ((state_n == WR_HI) || (state_n == RD_HI)) ? HI_HALF : LO_HALF;
  end

  // Outputs are registered from the next state so the bus view changes exactly on state entry.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      cnt_q          <= 2'd0;
      lo_q           <= '0;
      hi_q           <= '0;
      sdram_readdata <= '0;
      sdram_finished <= 1'b0;
      sdr_address    <= '0;
      sdr_read       <= 1'b0;
      sdr_write      <= 1'b0;
      sdr_writedata  <= '0;
    end else begin
      state          <= state_n;
      addr_q         <= addr_n;
      data_q         <= data_n;
      cnt_q          <= cnt_n;
      lo_q           <= lo_n;
      hi_q           <= hi_n;
      sdram_finished <= (state_n == DONE);
      sdr_write      <= (state_n == WR_LO) || (state_n == WR_HI);
      sdr_read       <= (state_n == RD_LO) || (state_n == RD_HI);
      sdr_address    <= {addr_n, half_sel};
      sdr_writedata  <= (state_n == WR_HI) ? data_n[WORD_W-1:HALF_W] : data_n[HALF_W-1:0];
      if ((state == RD_WAIT) && (state_n == DONE)) begin
        sdram_readdata <= {hi_n, lo_n};
      end
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb/tb_sdram_word_bridge.sv - self-checking bench with a behavioural SDRAM controller and word-level memory model
module tb_sdram_word_bridge;

  localparam int ADDR_W = 23;

  logic              avm_clk = 1'b0;
  logic              avm_rst_n = 1'b0;
  logic [ADDR_W-1:0] sdram_addr = '0;
  logic              sdram_read = 1'b0;
  logic              sdram_write = 1'b0;
  logic [31:0]       sdram_writedata = '0;
  logic [31:0]       sdram_readdata;
  logic              sdram_finished;
  logic [ADDR_W:0]   sdr_address;
  logic              sdr_read;
  logic              sdr_write;
  logic [15:0]       sdr_writedata;
  logic [15:0]       sdr_readdata = '0;
  logic              sdr_readdatavalid = 1'b0;
  logic              sdr_waitrequest = 1'b0;

  sdram_word_bridge #(.ADDR_W(ADDR_W)) dut (
    .avm_clk          (avm_clk),
    .avm_rst_n        (avm_rst_n),
    .sdram_addr       (sdram_addr),
    .sdram_read       (sdram_read),
    .sdram_write      (sdram_write),
    .sdram_writedata  (sdram_writedata),
    .sdram_readdata   (sdram_readdata),
    .sdram_finished   (sdram_finished),
    .sdr_address      (sdr_address),
    .sdr_read         (sdr_read),
    .sdr_write        (sdr_write),
    .sdr_writedata    (sdr_writedata),
    .sdr_readdata     (sdr_readdata),
    .sdr_readdatavalid(sdr_readdatavalid),
    .sdr_waitrequest  (sdr_waitrequest)
  );

  always #5 avm_clk = ~avm_clk;

  typedef struct {
    int              c;
    logic [ADDR_W:0] a;
    logic [15:0]     d;
    bit              acc;
  } beat_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } resp_t;

  beat_t       wlog[$];
  beat_t       rlog[$];
  resp_t       pend[$];
  logic [15:0] mem[logic [ADDR_W:0]];
  logic [31:0] wmem[logic [ADDR_W-1:0]];

  int          cyc = 0;
  int          fin_cnt = 0;
  int          fin_cyc = 0;
  logic [31:0] fin_data = '0;
  int          rd_strobes = 0;
  int          force_wait = 0;
  int          wait_pct = 0;
  int          stray_pct = 0;
  int          lat = 2;
  bit          scramble = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] half_default(input logic [ADDR_W:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a);
    if (wmem.exists(a)) return wmem[a];
    return {half_default({a, 1'b1}), half_default({a, 1'b0})};
  endfunction

  // Controller model: decides waitrequest for the current cycle, logs strobes, returns read beats after lat cycles.
  always @(negedge avm_clk) begin
    bit          w;
    bit          strobe;
    logic [15:0] rd;
    cyc++;
    strobe = sdr_write || sdr_read;
    w = 1'b0;
    if (strobe && force_wait > 0) begin
      w = 1'b1;
      force_wait--;
    end else if (strobe && wait_pct > 0 && $urandom_range(0, 99) < wait_pct) begin
      w = 1'b1;
    end
    sdr_waitrequest = w;
    if (sdr_write) begin
      wlog.push_back('{c: cyc, a: sdr_address, d: sdr_writedata, acc: !w});
      if (!w) mem[sdr_address] = sdr_writedata;
    end
    if (sdr_read) begin
      rd_strobes++;
      rlog.push_back('{c: cyc, a: sdr_address, d: 16'h0, acc: !w});
      if (!w) begin
        rd = mem.exists(sdr_address) ? mem[sdr_address] : half_default(sdr_address);
        pend.push_back('{due: cyc + lat, d: rd});
      end
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      sdr_readdatavalid = 1'b1;
      sdr_readdata      = pend[0].d;
      void'(pend.pop_front());
    end else begin
      sdr_readdata      = 16'($urandom);
      sdr_readdatavalid = !strobe && pend.size() == 0 && stray_pct > 0 &&
                          ($urandom_range(0, 99) < stray_pct);
    end
    if (sdram_finished) begin
      fin_cnt++;
      fin_cyc  = cyc;
      fin_data = sdram_readdata;
    end
  end

  task automatic run_txn(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, output int start, output bit done);
    int f0;
    @(negedge avm_clk);
    #1;
    sdram_addr      = a;
    sdram_writedata = d;
    sdram_write     = wr;
    sdram_read      = rd;
    start           = cyc;
    f0              = fin_cnt;
    done            = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge avm_clk);
      #1;
      if (fin_cnt != f0) begin
        done = 1'b1;
        break;
      end
      if (scramble) begin
        sdram_addr      = 23'($urandom);
        sdram_writedata = $urandom;
      end
    end
    sdram_write = 1'b0;
    sdram_read  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({sdr_read, sdr_write, sdram_finished} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b required=000", {sdr_read, sdr_write, sdram_finished});
    end
    n_checks++;
    if ({sdr_address, sdr_writedata, sdram_readdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses addr=%h wdata=%h rdata=%h required all zero",
               sdr_address, sdr_writedata, sdram_readdata);
    end
    @(negedge avm_clk);
    #1 avm_rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    int st; bit ok; int w0;
    wait_pct = 0;
    w0 = wlog.size();
    run_txn(1, 0, 23'h000010, 32'hDEADBEEF, st, ok);
    wmem[23'h000010] = 32'hDEADBEEF;
    n_checks++;
    if (!ok || wlog.size() - w0 != 2) begin
      n_fail++;
      $display("FAIL write_basic_count done=%0d beats=%0d required done=1 beats=2", ok, wlog.size() - w0);
    end else begin
      n_checks++;
      if (wlog[w0].c != st + 1 || wlog[w0].a !== 24'h000020 || wlog[w0].d !== 16'hBEEF || !wlog[w0].acc) begin
        n_fail++;
        $display("FAIL write_basic_lo cyc=%0d addr=%h data=%h required cyc=%0d addr=000020 data=beef",
                 wlog[w0].c - st, wlog[w0].a, wlog[w0].d, 1);
      end
      n_checks++;
      if (wlog[w0+1].c != st + 2 || wlog[w0+1].a !== 24'h000021 || wlog[w0+1].d !== 16'hDEAD) begin
        n_fail++;
        $display("FAIL write_basic_hi cyc=%0d addr=%h data=%h required cyc=2 addr=000021 data=dead",
                 wlog[w0+1].c - st, wlog[w0+1].a, wlog[w0+1].d);
      end
    end
    n_checks++;
    if (fin_cyc != st + 3) begin
      n_fail++;
      $display("FAIL write_basic_finish cyc=%0d required=3", fin_cyc - st);
    end
  endtask

  task automatic test_write_wait();
    int st; bit ok; int w0;
    w0 = wlog.size();
    force_wait = 2;
    run_txn(1, 0, 23'h000010, 32'hDEADBEEF, st, ok);
    n_checks++;
    if (!ok || wlog.size() - w0 != 4) begin
      n_fail++;
      $display("FAIL write_wait_count done=%0d strobes=%0d required done=1 strobes=4", ok, wlog.size() - w0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (wlog[w0+k].c != st + 1 + k || wlog[w0+k].a !== 24'h000020 || wlog[w0+k].d !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL write_wait_hold[%0d] cyc=%0d addr=%h data=%h required cyc=%0d addr=000020 data=beef",
                   k, wlog[w0+k].c - st, wlog[w0+k].a, wlog[w0+k].d, 1 + k);
        end
      end
      n_checks++;
      if (wlog[w0+3].c != st + 4 || wlog[w0+3].a !== 24'h000021 || wlog[w0+3].d !== 16'hDEAD) begin
        n_fail++;
        $display("FAIL write_wait_hi cyc=%0d addr=%h data=%h required cyc=4 addr=000021 data=dead",
                 wlog[w0+3].c - st, wlog[w0+3].a, wlog[w0+3].d);
      end
    end
    n_checks++;
    if (fin_cyc != st + 5) begin
      n_fail++;
      $display("FAIL write_wait_finish cyc=%0d required=5", fin_cyc - st);
    end
  endtask

  task automatic test_read_latency();
    int st; bit ok;
    logic [ADDR_W-1:0] a;
    for (int l = 1; l <= 4; l++) begin
      lat = l;
      a   = 23'($urandom);
      run_txn(0, 1, a, 32'h0, st, ok);
      n_checks++;
      if (!ok || fin_cyc != st + 3 + l || fin_data !== exp_word(a)) begin
        n_fail++;
        $display("FAIL read_latency[L=%0d] done=%0d cyc=%0d data=%h required cyc=%0d data=%h",
                 l, ok, fin_cyc - st, fin_data, 3 + l, exp_word(a));
      end
    end
  endtask

  task automatic test_read_l2();
    int st; bit ok; int r0;
    lat = 2;
    mem[24'hFFFFFE]  = 16'h5678;
    mem[24'hFFFFFF]  = 16'h1234;
    wmem[23'h7FFFFF] = 32'h12345678;
    r0 = rlog.size();
    run_txn(0, 1, 23'h7FFFFF, 32'h0, st, ok);
    n_checks++;
    if (!ok || rlog.size() - r0 != 2) begin
      n_fail++;
      $display("FAIL read_l2_count done=%0d strobes=%0d required done=1 strobes=2", ok, rlog.size() - r0);
    end else begin
      n_checks++;
      if (rlog[r0].a !== 24'hFFFFFE || rlog[r0+1].a !== 24'hFFFFFF ||
          rlog[r0].c != st + 1 || rlog[r0+1].c != st + 2) begin
        n_fail++;
        $display("FAIL read_l2_addr got=%h@%0d,%h@%0d required fffffe@1,ffffff@2",
                 rlog[r0].a, rlog[r0].c - st, rlog[r0+1].a, rlog[r0+1].c - st);
      end
    end
    n_checks++;
    if (fin_cyc != st + 5 || fin_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_l2_data cyc=%0d data=%h required cyc=5 data=12345678", fin_cyc - st, fin_data);
    end
  endtask

  task automatic test_simultaneous();
    int st; bit ok; int rs0; int w0; int f1; int acc;
    rs0 = rd_strobes;
    w0  = wlog.size();
    run_txn(1, 1, 23'h000123, 32'h0BADF00D, st, ok);
    wmem[23'h000123] = 32'h0BADF00D;
    acc = 0;
    for (int k = w0; k < wlog.size(); k++) if (wlog[k].acc) acc++;
    n_checks++;
    if (!ok || acc != 2 || rd_strobes != rs0) begin
      n_fail++;
      $display("FAIL simultaneous done=%0d writes=%0d reads=%0d required done=1 writes=2 reads=0",
               ok, acc, rd_strobes - rs0);
    end
    f1 = fin_cnt;
    repeat (6) @(negedge avm_clk);
    #1;
    n_checks++;
    if (fin_cnt != f1 || rd_strobes != rs0) begin
      n_fail++;
      $display("FAIL simultaneous_no_queue extra_finish=%0d reads=%0d required 0 0", fin_cnt - f1, rd_strobes - rs0);
    end
    n_checks++;
    if (sdram_readdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL readdata_hold got=%h required=12345678", sdram_readdata);
    end
  endtask

  task automatic test_back_to_back();
    int st; bit ok; int w0; int f0; int acc; bit bad;
    logic [ADDR_W-1:0] a[3];
    logic [31:0]       d[3];
    w0 = wlog.size();
    f0 = fin_cnt;
    for (int i = 0; i < 3; i++) begin
      a[i] = 23'h000200 + 23'(i);
      d[i] = $urandom;
      run_txn(1, 0, a[i], d[i], st, ok);
      wmem[a[i]] = d[i];
    end
    acc = 0;
    bad = 0;
    for (int k = w0; k < wlog.size(); k++) begin
      if (wlog[k].acc) begin
        if (acc < 6 && (wlog[k].a !== {a[acc/2], 1'(acc % 2)} ||
                        wlog[k].d !== ((acc % 2) ? d[acc/2][31:16] : d[acc/2][15:0]))) bad = 1;
        acc++;
      end
    end
    n_checks++;
    if (fin_cnt - f0 != 3 || acc != 6 || bad) begin
      n_fail++;
      $display("FAIL back_to_back finishes=%0d writes=%0d order_err=%0d required 3 6 0", fin_cnt - f0, acc, bad);
    end
  endtask

  task automatic test_reset_mid();
    int st; bit ok; int f0; int w0; int acc;
    f0 = fin_cnt;
    @(negedge avm_clk);
    #1;
    sdram_addr = 23'h024680; sdram_writedata = 32'hCAFEF00D; sdram_write = 1'b1;
    @(negedge avm_clk);
    @(negedge avm_clk);
    #1;
    n_checks++;
    if (sdr_write !== 1'b1 || sdr_address !== {23'h024680, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_wrhi write=%b addr=%h required write=1 addr=%h", sdr_write, sdr_address, {23'h024680, 1'b1});
    end
    #1 avm_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sdr_write, sdr_read, sdram_finished} !== 3'b000 || sdr_address !== '0 || sdr_writedata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async strobes=%b addr=%h wdata=%h required all zero",
               {sdr_write, sdr_read, sdram_finished}, sdr_address, sdr_writedata);
    end
    sdram_write = 1'b0;
    repeat (2) @(negedge avm_clk);
    #1 avm_rst_n = 1'b1;
    repeat (4) @(negedge avm_clk);
    #1;
    n_checks++;
    if (fin_cnt != f0) begin
      n_fail++;
      $display("FAIL reset_mid_no_finish pulses=%0d required=0", fin_cnt - f0);
    end
    w0 = wlog.size();
    run_txn(1, 0, 23'h024680, 32'h13579BDF, st, ok);
    wmem[23'h024680] = 32'h13579BDF;
    acc = 0;
    for (int k = w0; k < wlog.size(); k++) if (wlog[k].acc) acc++;
    n_checks++;
    if (!ok || acc != 2 || fin_cyc != st + 3 || wlog[w0].d !== 16'h9BDF || wlog[w0+1].d !== 16'h1357) begin
      n_fail++;
      $display("FAIL reset_mid_recover done=%0d writes=%0d cyc=%0d required done=1 writes=2 cyc=3", ok, acc, fin_cyc - st);
    end
  endtask

  task automatic test_random();
    int st; bit ok; int w0; int r0; int acc; bit bad; int racc;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    bit                wr;
    wait_pct  = 25;
    stray_pct = 20;
    scramble  = 1;
    for (int t = 0; t < 40; t++) begin
      wr  = $urandom_range(0, 1);
      a   = ($urandom_range(0, 1) == 1) ? 23'h000100 + 23'($urandom_range(0, 7)) : 23'($urandom);
      d   = $urandom;
      lat = $urandom_range(1, 4);
      w0  = wlog.size();
      r0  = rlog.size();
      run_txn(wr, !wr, a, d, st, ok);
      racc = 0;
      for (int k = r0; k < rlog.size(); k++) if (rlog[k].acc) racc++;
      if (wr) begin
        acc = 0;
        bad = 0;
        for (int k = w0; k < wlog.size(); k++) begin
          if (wlog[k].a !== {a, (acc == 0) ? 1'b0 : 1'b1} ||
              wlog[k].d !== ((acc == 0) ? d[15:0] : d[31:16])) bad = 1;
          if (wlog[k].acc) acc++;
        end
        wmem[a] = d;
        n_checks++;
        if (!ok || acc != 2 || bad || racc != 0) begin
          n_fail++;
          $display("FAIL random_write[%0d] a=%h done=%0d writes=%0d bad=%0d reads=%0d required 1 2 0 0",
                   t, a, ok, acc, bad, racc);
        end
      end else begin
        n_checks++;
        if (!ok || fin_data !== exp_word(a) || racc != 2 || wlog.size() != w0) begin
          n_fail++;
          $display("FAIL random_read[%0d] a=%h done=%0d data=%h reads=%0d required data=%h reads=2",
                   t, a, ok, fin_data, racc, exp_word(a));
        end
      end
    end
    scramble  = 0;
    stray_pct = 0;
    wait_pct  = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_wait();
    test_read_latency();
    test_read_l2();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge avm_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_word_bridge.md
# sdram_word_bridge

Downstream of the RS232 loader, the bridge converts its 32-bit word request/finished handshake into 16-bit Avalon-MM transfers to the SDRAM controller.
- Each accepted write becomes two half-word writes, low half first.
- Each accepted read becomes two pipelined half-word reads, reassembled into one 32-bit word.
- `sdram_finished` pulses once per completed word.

## Interface
- `ADDR_W`, 23: client word-address width; the controller half-word address is `ADDR_W+1`.
- `avm_clk`  in  1: sole clock, all logic on the rising edge.
- `avm_rst_n`  in  1: asynchronous, active-low reset.
- `sdram_addr`  in  `ADDR_W`: client word address.
- `sdram_read`  in  1: client read request; level-held until finished.
- `sdram_write`  in  1: client write request; level-held until finished.
- `sdram_writedata`  in  32: client write word.
- `sdram_readdata`  out  32: assembled read word; valid while `sdram_finished`=1 and held until the next read completes.
- `sdram_finished`  out  1: one-cycle completion pulse.
- `sdr_address`  out  `ADDR_W+1`: half-word address, `{word_addr, half}`.
- `sdr_read`  out  1: controller read strobe.
- `sdr_write`  out  1: controller write strobe.
- `sdr_writedata`  out  16: controller write half-word.
- `sdr_readdata`  in  16: controller read half-word.
- `sdr_readdatavalid`  in  1: controller read data valid.
- `sdr_waitrequest`  in  1: controller stall.

## Operation
**States:** IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, DONE.

**Accept (IDLE only):**
- If `sdram_write`=1: latch address and data, go to WR_LO.
- Else if `sdram_read`=1: latch address, clear the return count, go to RD_LO.
- Write has priority when both requests are high. The read is ignored, not queued.

**Write path:**
- WR_LO: drive `sdr_write`=1, address `{a,0}`, data `d[15:0]`. Hold while `sdr_waitrequest`=1, then go to WR_HI.
- WR_HI: address `{a,1}`, data `d[31:16]`. On no-wait, go to DONE.

**Read path:**
- RD_LO issues `{a,0}` and RD_HI issues `{a,1}`, each held under waitrequest.
- Then RD_WAIT until two `sdr_readdatavalid` beats have been counted.
- The first beat goes to `[15:0]` and the second to `[31:16]`. Beats may arrive during RD_LO or RD_HI and must be captured there.
- RD_WAIT goes to DONE when the count reaches 2, including when the second beat arrives in the same cycle the state is entered.

**Completion:**
- DONE asserts `sdram_finished`=1 for exactly one cycle, then returns to IDLE.
- The client deasserts its request on the edge after the pulse. A request still high in IDLE on that next cycle is treated as a new transaction.
- Inputs are sampled only in IDLE. Address and data changes mid-transaction are ignored.
- A `sdr_readdatavalid` beat seen outside the read states is dropped.

## Timing
**Outputs:**
- All outputs are registered.
- Reset value of every output is 0, and the state resets to IDLE.

**Write latency:**
- Request high in IDLE at cycle 0.
- `sdr_write` low-half in cycle 1, high-half in cycle 2.
- `sdram_finished` in cycle 3.
- Each waitrequest cycle adds one.

**Read latency:**
- `sdr_read` in cycles 1 and 2.
- With controller latency L, beats arrive at cycles 1+L and 2+L, and `sdram_finished` follows at cycle 3+L.

**Avalon rules:**
- Address, data and strobe are held stable while waitrequest=1.
- A strobe is never asserted in IDLE, DONE or RD_WAIT.

**Reset mid-transaction:**
- Strobes and `sdram_finished` drop immediately (asynchronously).
- The pending transaction is abandoned, with no completion pulse.

**Counters:** the return count is 2 bits and saturates at 2; it does not wrap.

## Structure
**Package `sdram_bridge_pkg`:**
- State enum `bridge_state_t`.
- `HALF_W`=16, `WORD_W`=32.
- `LO_HALF`=1'b0, `HI_HALF`=1'b1.

**Module:** single module, no sub-module. The read reassembly (count plus two 16-bit registers) stays inline.

## Test plan
- **Write, no wait:** write `a=0x000010`, `d=0xDEADBEEF`. Expect `sdr_write` at addr `0x000020` data `0xBEEF` at cycle 1, then addr `0x000021` data `0xDEAD` at cycle 2, then finished at cycle 3.
- **Write with waitrequest:** same write with waitrequest held for 2 cycles during WR_LO. Expect `0xBEEF` held stable for 3 cycles and finished at cycle 5.
- **Read, L=2:** read `a=0x7FFFFF`. Expect addresses `0xFFFFFE` and `0xFFFFFF`; beats `0x5678` and `0x1234` give `sdram_readdata=0x12345678` with finished at cycle 5.
- **Simultaneous read and write:** both requests high. Expect only the write strobes, and no `sdr_read` for the whole transaction.
- **Back-to-back writes:** loader-style client, 3 sequential writes. Expect exactly 3 finished pulses and 6 `sdr_write` beats, with no duplicate transaction.
- **Reset mid-transaction:** `avm_rst_n` low during WR_HI. Expect all outputs 0 immediately, no finished pulse, and a clean write after release.
